// File: rtl/utils.sv
// Shared types for result checking: the stats record, scoreboard FSM states
// and a saturating 32-bit increment used by the pass/fail counters.
package utils;

  typedef struct packed {
    logic [31:0] pass_cnt;
    logic [31:0] fail_cnt;
  } test_stats;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_RUN,
    SB_DONE
  } sb_state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    r = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding expected elements until the matching DUT
// element arrives. Head data is read combinationally so a pop can compare in
// the same cycle. Flush empties the FIFO without touching storage.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/result_scoreboard.sv
// Scoreboard comparing a DUT result stream against a buffered expected
// stream under a bit mask, counting passes/fails and recording the first
// mismatch index. Raises a one-cycle done once the last item is counted.
module result_scoreboard
  import utils::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int EXP_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_items,
  input  logic [DATA_W-1:0] cmp_mask,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [DATA_W-1:0] act_data,
  output logic              busy,
  output logic              done,
  output test_stats         stats,
  output logic              first_fail_vld,
  output logic [CNT_W-1:0]  first_fail_idx
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  pushed_q, pushed_d;
  logic [CNT_W-1:0]  cmp_idx_q, cmp_idx_d;
  logic [CNT_W-1:0]  ff_idx_q, ff_idx_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  test_stats         stats_q, stats_d;
  logic              ff_vld_q, ff_vld_d;
  logic              done_q, done_d;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              start_acc, exp_fire, act_fire, cmp_pass, last_cmp;

  // A start during RUN is dropped; it is honoured from IDLE or DONE.
  assign start_acc = start && (state_q != SB_RUN);
  assign exp_ready = (state_q == SB_RUN) && !fifo_full && (pushed_q < num_q);
  assign act_ready = (state_q == SB_RUN) && !fifo_empty;
  assign exp_fire  = exp_valid && exp_ready;
  assign act_fire  = act_valid && act_ready;
  assign cmp_pass  = (((act_data ^ fifo_head) & mask_q) == '0);
  assign last_cmp  = (cmp_idx_q == num_q - CNT_ONE);

  assign busy           = (state_q == SB_RUN);
  assign done           = done_q;
  assign stats          = stats_q;
  assign first_fail_vld = ff_vld_q;
  assign first_fail_idx = ff_idx_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (EXP_DEPTH)
  ) u_exp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start_acc),
    .push      (exp_fire),
    .pop       (act_fire),
    .push_data (exp_data),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state logic: run setup on start, then count compares until the last.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    mask_d    = mask_q;
    pushed_d  = pushed_q;
    cmp_idx_d = cmp_idx_q;
    stats_d   = stats_q;
    ff_vld_d  = ff_vld_q;
    ff_idx_d  = ff_idx_q;
    done_d    = 1'b0;
    case (state_q)
      SB_IDLE, SB_DONE: begin
        if (start_acc) begin
          num_d     = num_items;
          mask_d    = cmp_mask;
          pushed_d  = '0;
          cmp_idx_d = '0;
          stats_d   = '0;
          ff_vld_d  = 1'b0;
          ff_idx_d  = '0;
          if (num_items == '0) begin
            state_d = SB_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SB_RUN;
          end
        end
      end
      SB_RUN: begin
        if (exp_fire) pushed_d = pushed_q + CNT_ONE;
        if (act_fire) begin
          cmp_idx_d = cmp_idx_q + CNT_ONE;
          if (cmp_pass) begin
            stats_d.pass_cnt = sat_inc32(stats_q.pass_cnt);
          end else begin
            stats_d.fail_cnt = sat_inc32(stats_q.fail_cnt);
            if (!ff_vld_q) begin
              ff_vld_d = 1'b1;
              ff_idx_d = cmp_idx_q;
            end
          end
          if (last_cmp) begin
            state_d = SB_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SB_IDLE;
      num_q     <= '0;
      mask_q    <= '0;
      pushed_q  <= '0;
      cmp_idx_q <= '0;
      stats_q   <= '0;
      ff_vld_q  <= 1'b0;
      ff_idx_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      mask_q    <= mask_d;
      pushed_q  <= pushed_d;
      cmp_idx_q <= cmp_idx_d;
      stats_q   <= stats_d;
      ff_vld_q  <= ff_vld_d;
      ff_idx_q  <= ff_idx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_result_scoreboard.sv
// Bench for result_scoreboard: directed and randomized runs checked against
// a stream-level model (in-order FIFO occupancy, masked compare counts).
module tb_result_scoreboard;
  import utils::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 8;
  localparam int TMO    = 2000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  num_items;
  logic [DATA_W-1:0] cmp_mask;
  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data;
  logic              act_valid;
  logic              act_ready;
  logic [DATA_W-1:0] act_data;
  logic              busy;
  logic              done;
  test_stats         stats;
  logic              first_fail_vld;
  logic [CNT_W-1:0]  first_fail_idx;

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] ev [64];
  logic [31:0] av [64];

  always #5 clk = ~clk;

  result_scoreboard #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .EXP_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_items      (num_items),
    .cmp_mask       (cmp_mask),
    .exp_valid      (exp_valid),
    .exp_ready      (exp_ready),
    .exp_data       (exp_data),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .act_data       (act_data),
    .busy           (busy),
    .done           (done),
    .stats          (stats),
    .first_fail_vld (first_fail_vld),
    .first_fail_idx (first_fail_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run: start, stream both sides with random gaps, check every cycle.
  task automatic run_case(input string tag, input int n, input logic [31:0] mask,
                          input int exp_gap, input int act_gap, input bit ahead,
                          input int inj_at, input int abort_at, output bit saw_full);
    int pushes, pops, cyc, occ, m_ffi;
    logic [31:0] m_pass, m_fail;
    bit m_ffv, e_rdy, a_rdy, e_v, a_v;
    saw_full = 0;
    pushes = 0; pops = 0; cyc = 0; m_ffi = 0;
    m_pass = 0; m_fail = 0; m_ffv = 0;
    start = 1'b1; num_items = n[CNT_W-1:0]; cmp_mask = mask;
    tick();
    start = 1'b0;
    chk({tag, ":busy_start"}, busy, n != 0);
    chk({tag, ":done_start"}, done, n == 0);
    if (n == 0) begin
      chk({tag, ":stats_zero"}, stats, 64'd0);
      tick();
      chk({tag, ":done_once"}, done, 1'b0);
      $display("run %s n=%0d pass=%0d fail=%0d", tag, n, stats.pass_cnt, stats.fail_cnt);
      return;
    end
    while (pops < n && cyc < TMO) begin
      occ   = pushes - pops;
      e_rdy = (occ < DEPTH) && (pushes < n);
      a_rdy = (occ > 0);
      if (occ == DEPTH) saw_full = 1;
      chk({tag, ":exp_ready"}, exp_ready, e_rdy);
      chk({tag, ":act_ready"}, act_ready, a_rdy);
      chk({tag, ":stats_run"}, stats, {m_pass, m_fail});
      chk({tag, ":ffv_run"}, first_fail_vld, m_ffv);
      chk({tag, ":ffi_run"}, first_fail_idx, m_ffi);
      chk({tag, ":busy_run"}, busy, 1'b1);
      chk({tag, ":done_run"}, done, 1'b0);
      if (cyc == abort_at) begin
        exp_valid = 1'b0; act_valid = 1'b0; start = 1'b0;
        return;
      end
      e_v = (pushes < n) && (ahead || $urandom_range(99) >= exp_gap);
      a_v = (pops < n) && (!ahead || pushes >= DEPTH || pushes == n) &&
            ($urandom_range(99) >= act_gap);
      exp_valid = e_v;
      exp_data  = e_v ? ev[pushes] : $urandom();
      act_valid = a_v;
      act_data  = a_v ? av[pops] : $urandom();
      start     = (cyc == inj_at);
      if (cyc == inj_at) begin
        num_items = 1;
        cmp_mask  = 32'd0;
      end
      tick();
      if (a_v && a_rdy) begin
        if (((ev[pops] ^ av[pops]) & mask) == 32'd0) m_pass++;
        else begin
          m_fail++;
          if (!m_ffv) begin m_ffv = 1; m_ffi = pops; end
        end
        pops++;
      end
      if (e_v && e_rdy) pushes++;
      cyc++;
    end
    start = 1'b0; exp_valid = 1'b0; act_valid = 1'b0;
    if (pops < n) begin
      chk({tag, ":timeout"}, pops, n);
      return;
    end
    chk({tag, ":done_end"}, done, 1'b1);
    chk({tag, ":busy_end"}, busy, 1'b0);
    chk({tag, ":exp_ready_end"}, exp_ready, 1'b0);
    chk({tag, ":act_ready_end"}, act_ready, 1'b0);
    chk({tag, ":stats_end"}, stats, {m_pass, m_fail});
    chk({tag, ":ffv_end"}, first_fail_vld, m_ffv);
    chk({tag, ":ffi_end"}, first_fail_idx, m_ffi);
    tick();
    chk({tag, ":done_pulse"}, done, 1'b0);
    chk({tag, ":stats_hold"}, stats, {m_pass, m_fail});
    $display("run %s n=%0d pass=%0d fail=%0d ffv=%0d ffi=%0d", tag, n,
             stats.pass_cnt, stats.fail_cnt, first_fail_vld, first_fail_idx);
  endtask

  initial begin
    bit full_seen;
    int exp_pass;
    logic [31:0] rmask;

    rst_n = 1'b0; start = 1'b0; num_items = '0; cmp_mask = '0;
    exp_valid = 1'b0; exp_data = '0; act_valid = 1'b0; act_data = '0;
    tick(); tick();
    chk("rst:busy", busy, 1'b0);
    chk("rst:done", done, 1'b0);
    chk("rst:exp_ready", exp_ready, 1'b0);
    chk("rst:act_ready", act_ready, 1'b0);
    chk("rst:stats", stats, 64'd0);
    chk("rst:ffv", first_fail_vld, 1'b0);
    chk("rst:ffi", first_fail_idx, 16'd0);
    rst_n = 1'b1;
    tick();

    // All four match.
    for (int i = 0; i < 4; i++) begin ev[i] = i + 1; av[i] = i + 1; end
    run_case("match4", 4, 32'hFFFF_FFFF, 30, 30, 0, -1, -1, full_seen);
    chk("match4:stats", stats, {32'd4, 32'd0});
    chk("match4:ffv", first_fail_vld, 1'b0);

    // Two mismatches, first at index 1 (started from DONE).
    av[1] = 9; av[3] = 7;
    run_case("mism4", 4, 32'hFFFF_FFFF, 20, 20, 0, -1, -1, full_seen);
    chk("mism4:stats", stats, {32'd2, 32'd2});
    chk("mism4:ffv", first_fail_vld, 1'b1);
    chk("mism4:ffi", first_fail_idx, 16'd1);

    // Back-to-back pass run after a failing one: counts independent.
    for (int i = 0; i < 4; i++) begin ev[i] = i + 1; av[i] = i + 1; end
    run_case("b2b", 4, 32'hFFFF_FFFF, 0, 0, 0, -1, -1, full_seen);
    chk("b2b:stats", stats, {32'd4, 32'd0});
    chk("b2b:ffv", first_fail_vld, 1'b0);

    // Masked compare ignores upper half.
    ev[0] = 32'h1234_00AA; av[0] = 32'hFFFF_00AA;
    run_case("mask", 1, 32'h0000_FFFF, 0, 0, 0, -1, -1, full_seen);
    chk("mask:stats", stats, {32'd1, 32'd0});

    // Zero items: done one cycle after start, stats cleared.
    run_case("zero", 0, 32'hFFFF_FFFF, 0, 0, 0, -1, -1, full_seen);
    chk("zero:ffv", first_fail_vld, 1'b0);

    // Start pulse in the middle of RUN is ignored.
    for (int i = 0; i < 6; i++) begin ev[i] = $urandom(); av[i] = ev[i]; end
    run_case("start_in_run", 6, 32'hFFFF_FFFF, 10, 10, 0, 3, -1, full_seen);
    chk("start_in_run:stats", stats, {32'd6, 32'd0});

    // Expected stream runs 8 ahead; buffer must fill and nothing is lost.
    for (int i = 0; i < 20; i++) begin ev[i] = $urandom(); av[i] = ev[i]; end
    run_case("ahead20", 20, 32'hFFFF_FFFF, 0, 40, 1, -1, -1, full_seen);
    chk("ahead20:full_seen", full_seen, 1'b1);
    chk("ahead20:stats", stats, {32'd20, 32'd0});

    // Random mask with random single-bit corruption.
    rmask = $urandom();
    exp_pass = 0;
    for (int i = 0; i < 30; i++) begin
      ev[i] = $urandom();
      av[i] = ($urandom_range(2) == 0) ? (ev[i] ^ (32'd1 << $urandom_range(31))) : ev[i];
      if (((ev[i] ^ av[i]) & rmask) == 32'd0) exp_pass++;
    end
    run_case("rand30", 30, rmask, 25, 25, 0, -1, -1, full_seen);
    chk("rand30:stats", stats, {exp_pass[31:0], 32'(30 - exp_pass)});

    // Reset in the middle of a run after a mismatch was recorded.
    for (int i = 0; i < 10; i++) begin ev[i] = i; av[i] = i; end
    av[0] = 32'hDEAD;
    run_case("abort", 10, 32'hFFFF_FFFF, 0, 0, 0, -1, 6, full_seen);
    chk("abort:ffv_pre", first_fail_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort:busy", busy, 1'b0);
    chk("abort:done", done, 1'b0);
    chk("abort:exp_ready", exp_ready, 1'b0);
    chk("abort:act_ready", act_ready, 1'b0);
    chk("abort:stats", stats, 64'd0);
    chk("abort:ffv", first_fail_vld, 1'b0);
    chk("abort:ffi", first_fail_idx, 16'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort:no_done", done, 1'b0);
      chk("abort:idle", busy, 1'b0);
    end
    $display("run abort reset-mid-run done=%0d busy=%0d", done, busy);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/result_scoreboard.md
# result_scoreboard

Hardware scoreboard that produces the `test_stats` record consumed by the `utils` reporting functions. It sits at the output of a compute block under test. It takes the DUT's result stream and a reference (expected) stream, compares them element by element under a bit mask, and counts passes and failures. It then raises `done` so the bench can read `stats` and pass it to `print_result`.

## Interface
Parameters:
- DATA_W, 32, width of each result/expected element
- CNT_W, 16, width of the item-count field
- EXP_DEPTH, 8, depth of the expected-data buffer (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  one-cycle pulse; latches `num_items` and `cmp_mask`; accepted only in IDLE or DONE
- num_items  in  CNT_W  number of element pairs to compare
- cmp_mask  in  DATA_W  1 = bit is compared, 0 = bit ignored
- exp_valid  in  1  expected element valid
- exp_ready  out  1  scoreboard accepts expected element
- exp_data  in  DATA_W  expected element
- act_valid  in  1  DUT element valid
- act_ready  out  1  scoreboard accepts DUT element
- act_data  in  DATA_W  DUT element
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when the last compare has been counted
- stats  out  64  `utils::test_stats` (`pass_cnt`, `fail_cnt`)
- first_fail_vld  out  1  at least one mismatch has occurred since `start`
- first_fail_idx  out  CNT_W  index (0-based) of the first mismatch

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE→RUN on `start` when `num_items`≠0.
  - IDLE→DONE on `start` when `num_items`=0.
  - RUN→DONE on the compare of item `num_items`-1.
  - DONE→RUN or DONE on `start`, by the same rule as from IDLE.
  - `start` in RUN is ignored.
- On an accepted `start`, the block clears:
  - `stats`, `first_fail_vld` and `first_fail_idx`;
  - the expected-push counter and the compare counter;
  - the expected buffer.
- Expected path:
  - `exp_ready` = RUN && buffer not full && pushed < `num_items`.
  - An element is pushed into the buffer on `exp_valid && exp_ready`.
- DUT path:
  - `act_ready` = RUN && buffer not empty.
  - On `act_valid && act_ready`, the block pops the buffer head and compares it with `act_data`.
- Compare rule: pass iff `((act_data ^ head) & cmp_mask) == 0`.
  - Pass increments `pass_cnt`; fail increments `fail_cnt`.
  - Both counters are 32-bit and saturate at 2^32-1; they never wrap.
- First fail: on the first mismatch after `start`, `first_fail_idx` takes the current compare index and `first_fail_vld` is set. Later mismatches do not change either.
- Simultaneous push and pop on a non-empty buffer: both take effect and occupancy is unchanged.
- A push into an empty buffer is not visible to `act_ready` in the same cycle.
- Surplus DUT beats (beyond `num_items`) are never accepted, because `act_ready` is 0 outside RUN.

## Timing
- Reset values:
  - state IDLE;
  - `exp_ready`, `act_ready`, `busy`, `done` and `first_fail_vld` all 0;
  - `stats` 0 and `first_fail_idx` 0;
  - buffer empty.
- Reset mid-RUN discards everything; no `done` is produced.
- `start` at edge E puts the block in RUN from cycle E+1. `exp_ready` can be high in E+1; `act_ready` is high no earlier than E+2.
- A compare handshake at edge C updates `stats` and first-fail at C. The updated values are visible in cycle C+1.
- The last compare handshake at edge C:
  - moves the state to DONE;
  - drives `done`=1 for exactly cycle C+1;
  - deasserts `busy` in cycle C+1.
- A `start` with `num_items`=0 at edge E gives `done`=1 in cycle E+1, with `stats`=0.
- `stats` and first-fail hold their values in DONE until the next accepted `start`.
- Throughput is one compare per cycle once the buffer holds data.

## Structure
- Additions to package `utils`:
  - typedef `sb_state_e` {SB_IDLE, SB_RUN, SB_DONE};
  - function `sat_inc32`.
- `test_stats` stays in `utils` and is reused for `stats`.
- Sub-module `sync_fifo`:
  - parameters DATA_W and DEPTH;
  - ports: push, pop, full, empty, head data;
  - reset: async active-low;
  - flush input driven by the accepted `start`.

## Test plan
- `num_items`=4, mask all ones, exp={1,2,3,4}, act={1,2,3,4} → `done` pulse, pass=4, fail=0, `first_fail_vld`=0.
- `num_items`=4, act={1,9,3,7} → pass=2, fail=2, `first_fail_idx`=1.
- mask=0x0000_FFFF, exp=0x1234_00AA, act=0xFFFF_00AA → pass=1.
- Expected stream sent 8 beats ahead of DUT data with EXP_DEPTH=8:
  - `exp_ready` drops when the buffer is full;
  - random `act_valid` gaps;
  - `num_items`=20 → pass=20 and no beat lost or duplicated.
- Edge cases:
  - `num_items`=0 → `done` one cycle after `start`, stats=0.
  - `start` during RUN → ignored.
  - `rst_n` low mid-RUN → all outputs 0, no `done`.
- Two back-to-back runs (`start` in DONE) → stats cleared; second run's counts are independent of the first.
